vga_scene_ctrl: RTL
===================

# vga_scene_ctrl

Parametrised VGA scene controller for the wand-target game display: generates VGA timing and renders a configurable grid of IR targets plus full-screen game scenes (get-ready, times-up, leaderboard) in the active house colour. It sits between the processor/IR-receiver control signals and the VGA DAC pins, and generalises the fixed 25-target, single-mode display to N targets with per-target hit persistence and frame-synchronous scene switching.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33
- N_TGT, 25, number of IR targets (1..64)
- GRID_COLS, 5, grid columns; rows = ceil(N_TGT/GRID_COLS)
- CELL_W, 96 / CELL_H, 80, cell size in pixels
- GRID_X0, 80 / GRID_Y0, 40, grid top-left pixel
- HIT_HOLD, 30, frames a cell stays lit after a hit (1..255)
- COLOR_W, 8, bits per colour channel
- iVGA_CLK  in  1  pixel clock; all logic on rising edge
- iRST  in  1  asynchronous, active-high reset
- ir_in  in  N_TGT  raw IR hit flags, bit i = target i
- house  in  4  {R,H,S,G} house select (bit0 = G)
- leaderboard, get_ready, times_up  in  1 each  scene requests
- oHS, oVS  out  1  sync, active-low
- oBLANK_n  out  1  high during active video
- r_data, g_data, b_data  out  COLOR_W  pixel colour
- frame_tick  out  1  one-cycle pulse at last pixel of frame
- scene  out  2  current scene: PLAY=0, READY=1, TIMESUP=2, BOARD=3

## Operation
- h counter 0..H_TOTAL-1, v counter 0..V_TOTAL-1 (800/525 default); v increments on h wrap; both wrap to 0.
- Sync low while h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), same rule for v; active when h<H_ACTIVE and v<V_ACTIVE.
- Frame boundary = frame_tick cycle (h=H_TOTAL-1, v=V_TOTAL-1). On that edge only: scene register, house register, ir_in sample and hold counters update. Mid-frame input changes never alter the current frame.
- Scene select priority: times_up > leaderboard > get_ready > PLAY (none asserted).
- House colour (registered): G=(FF,00,00), S=(00,FF,00), H=(FF,FF,00), R=(00,00,FF) scaled to COLOR_W (MSB-aligned); priority G>S>H>R; none → grey (80,80,80).
- Hit hold: per target, counter width clog2(HIT_HOLD+1). Rising edge of sampled ir_in[i] (vs previous sample) loads HIT_HOLD; else nonzero counter decrements by 1 per frame; saturates at 0. Held-high input does not retrigger.
- PLAY: pixel inside grid at cell index k=row*GRID_COLS+col, k<N_TGT: house colour if hold[k]≠0, else dark grey (20,20,20); outside grid or k≥N_TGT: black. Column/row tracked by sub-counters, no dividers.
- READY: whole active area house colour >>1. TIMESUP: full red, blinks off when frame counter bit 4 = 1 (frame counter 8-bit, wraps). BOARD: top 40 lines house colour, rest black.
- Blanked pixels: colour 0.

## Timing
- Reset values: counters 0, oHS=1, oVS=1, oBLANK_n=0, colours 0, frame_tick=0, scene=PLAY, holds 0, samples 0, frame counter 0.
- Pixel pipeline latency 1 cycle: oHS/oVS/oBLANK_n/colour registered together, aligned to same (h,v).
- frame_tick asserted the cycle after counters reach frame end (registered); period H_TOTAL*V_TOTAL.
- New scene/holds visible from pixel (0,0) of the next frame.
- Reset mid-frame: all state returns to reset values asynchronously; timing restarts at (0,0) on release.

## Configuration
- HIT_FADE_EN defined: lit cell colour halved (>>1) when 0<hold[k]<HIT_HOLD/2, giving a two-step fade.
- Undefined: lit cells full house colour for the entire hold.

## Test plan
- Release reset → first oHS low 657 cycles after release, low for 96 cycles; frame_tick every 420000 cycles; oBLANK_n high 640 of every 800 cycles on lines 0..479.
- house=0001, pulse ir_in[0] mid-frame → cell 0 (x 80..175, y 40..119) red FF,00,00 from next frame for exactly 30 frames, then 20,20,20.
- ir_in[7] held high 100 frames → lit 30 frames only; drop then re-raise → reload to 30.
- times_up and get_ready asserted together mid-frame → scene stays 0 until frame_tick, then 2; screen red, dark on frames with counter bit4=1.
- house=0000, hit target 24 → cell (row 4, col 4) grey 80,80,80; house=0110 → green.
- Assert iRST mid-line → outputs immediately at reset values; after release, scene=PLAY, all cells dark.

Source files
------------

// File: rtl/vga_scene_ctrl_if.sv
// rtl/vga_scene_ctrl_if.sv - VGA DAC pin bundle driven by the scene controller
interface vga_scene_ctrl_if #(parameter int COLOR_W = 8);
    logic               oHS;
    logic               oVS;
    logic               oBLANK_n;
    logic [COLOR_W-1:0] r_data;
    logic [COLOR_W-1:0] g_data;
    logic [COLOR_W-1:0] b_data;

    modport master (output oHS, oVS, oBLANK_n, r_data, g_data, b_data);
    modport slave  (input  oHS, oVS, oBLANK_n, r_data, g_data, b_data);
endinterface

// File: rtl/vga_scene_ctrl.sv
// rtl/vga_scene_ctrl.sv - VGA timing plus target-grid / game-scene renderer
// Optional macro HIT_FADE_EN: lit cells drop to half brightness in the last half of their hold.
module vga_scene_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int N_TGT     = 25,
    parameter int GRID_COLS = 5,
    parameter int CELL_W    = 96,
    parameter int CELL_H    = 80,
    parameter int GRID_X0   = 80,
    parameter int GRID_Y0   = 40,
    parameter int HIT_HOLD  = 30,
    parameter int COLOR_W   = 8
) (
    input  logic             iVGA_CLK,
    input  logic             iRST,
    input  logic [N_TGT-1:0] ir_in,
    input  logic [3:0]       house,
    input  logic             leaderboard,
    input  logic             get_ready,
    input  logic             times_up,
    output logic             frame_tick,
    output logic [1:0]       scene,
    vga_scene_ctrl_if.master vga
);
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START    = H_ACTIVE + H_FP;
    localparam int HS_END      = HS_START + H_SYNC;
    localparam int VS_START    = V_ACTIVE + V_FP;
    localparam int VS_END      = VS_START + V_SYNC;
    localparam int ROWS        = (N_TGT + GRID_COLS - 1) / GRID_COLS;
    localparam int HW          = $clog2(HIT_HOLD + 1);
    localparam int XW          = $clog2(H_TOTAL);
    localparam int YW          = $clog2(V_TOTAL);
    localparam int BOARD_LINES = 40;

    typedef enum logic [1:0] {PLAY = 2'd0, READY = 2'd1, TIMESUP = 2'd2, BOARD = 2'd3} scene_t;

    function automatic logic [COLOR_W-1:0] scale8(input logic [7:0] c);
        logic [COLOR_W+7:0] t;
        t = {c, {COLOR_W{1'b0}}};
        return t[COLOR_W+7 -: COLOR_W];
    endfunction

    logic [XW-1:0] h, h_next;
    logic [YW-1:0] v, v_next;
    logic          h_end, frame_end;

    always_comb begin
        h_end     = (int'(h) == H_TOTAL - 1);
        frame_end = h_end && (int'(v) == V_TOTAL - 1);
        h_next    = h_end ? '0 : h + 1'b1;
        v_next    = v;
        if (h_end)
            v_next = (int'(v) == V_TOTAL - 1) ? '0 : v + 1'b1;
    end

    // Cell position tracked by sub-counters that run alongside h/v, so no divide is needed.
    logic        gx_on, gy_on;
    logic [15:0] cx, cy;
    logic [7:0]  col, row, row_base, k;

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            h        <= '0;
            v        <= '0;
            gx_on    <= (GRID_X0 == 0);
            gy_on    <= (GRID_Y0 == 0);
            cx       <= '0;
            cy       <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            h <= h_next;
            v <= v_next;
            if (int'(h_next) == GRID_X0) begin
                gx_on <= 1'b1;
                cx    <= '0;
                col   <= '0;
            end else if (h_next == '0) begin
                gx_on <= 1'b0;
            end else if (gx_on) begin
                if (int'(cx) == CELL_W - 1) begin
                    cx <= '0;
                    if (int'(col) == GRID_COLS - 1) gx_on <= 1'b0;
                    else                            col   <= col + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end
            if (h_end) begin
                if (int'(v_next) == GRID_Y0) begin
                    gy_on    <= 1'b1;
                    cy       <= '0;
                    row      <= '0;
                    row_base <= '0;
                end else if (v_next == '0) begin
                    gy_on <= 1'b0;
                end else if (gy_on) begin
                    if (int'(cy) == CELL_H - 1) begin
                        cy <= '0;
                        if (int'(row) == ROWS - 1) begin
                            gy_on <= 1'b0;
                        end else begin
                            row      <= row + 1'b1;
                            row_base <= row_base + 8'(GRID_COLS);
                        end
                    end else begin
                        cy <= cy + 1'b1;
                    end
                end
            end
        end
    end

    assign k = row_base + col;

    scene_t           scene_q, scene_d;
    logic [3:0]       house_q;
    logic [7:0]       fcnt;
    logic [N_TGT-1:0] ir_catch, ir_samp, ir_now;
    logic [HW-1:0]    hold [N_TGT];

    always_comb begin
        scene_d = scene_q;
        if (frame_end) begin
            if (times_up)         scene_d = TIMESUP;
            else if (leaderboard) scene_d = BOARD;
            else if (get_ready)   scene_d = READY;
            else                  scene_d = PLAY;
        end
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) scene_q <= PLAY;
        else      scene_q <= scene_d;
    end

    // Short IR pulses are caught during the frame and only acted on at the frame boundary.
    assign ir_now = ir_catch | ir_in;

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            house_q  <= '0;
            fcnt     <= '0;
            ir_catch <= '0;
            ir_samp  <= '0;
            for (int i = 0; i < N_TGT; i++) hold[i] <= '0;
        end else if (frame_end) begin
            house_q  <= house;
            fcnt     <= fcnt + 1'b1;
            ir_catch <= '0;
            ir_samp  <= ir_now;
            for (int i = 0; i < N_TGT; i++) begin
                if (ir_now[i] && !ir_samp[i]) hold[i] <= HW'(HIT_HOLD);
                else if (hold[i] != '0)       hold[i] <= hold[i] - 1'b1;
            end
        end else begin
            ir_catch <= ir_now;
        end
    end

    logic [COLOR_W-1:0] c_hi, c_mid, c_dark, hc_r, hc_g, hc_b, pr, pg, pb;
    logic [255:0]       lit_pad;
    logic               active;

    assign c_hi   = scale8(8'hFF);
    assign c_mid  = scale8(8'h80);
    assign c_dark = scale8(8'h20);
    assign active = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);

    always_comb begin
        hc_r = c_mid;
        hc_g = c_mid;
        hc_b = c_mid;
        if (house_q[0])      begin hc_r = c_hi; hc_g = '0;   hc_b = '0;   end
        else if (house_q[1]) begin hc_r = '0;   hc_g = c_hi; hc_b = '0;   end
        else if (house_q[2]) begin hc_r = c_hi; hc_g = c_hi; hc_b = '0;   end
        else if (house_q[3]) begin hc_r = '0;   hc_g = '0;   hc_b = c_hi; end
    end

    always_comb begin
        lit_pad = '0;
        for (int i = 0; i < N_TGT; i++) lit_pad[i] = (hold[i] != '0);
    end

`ifdef HIT_FADE_EN
    logic [255:0] fade_pad;
    always_comb begin
        fade_pad = '0;
        for (int i = 0; i < N_TGT; i++) fade_pad[i] = (int'(hold[i]) < HIT_HOLD / 2);
    end
`endif

    always_comb begin
        pr = '0;
        pg = '0;
        pb = '0;
        if (active) begin
            case (scene_q)
                PLAY: begin
                    if (gx_on && gy_on && int'(k) < N_TGT) begin
                        if (lit_pad[k]) begin
                            pr = hc_r;
                            pg = hc_g;
                            pb = hc_b;
`ifdef HIT_FADE_EN
                            if (fade_pad[k]) begin
                                pr = hc_r >> 1;
                                pg = hc_g >> 1;
                                pb = hc_b >> 1;
                            end
`endif
                        end else begin
                            pr = c_dark;
                            pg = c_dark;
                            pb = c_dark;
                        end
                    end
                end
                READY: begin
                    pr = hc_r >> 1;
                    pg = hc_g >> 1;
                    pb = hc_b >> 1;
                end
                TIMESUP: begin
                    if (!fcnt[4]) pr = c_hi;
                end
                BOARD: begin
                    if (int'(v) < BOARD_LINES) begin
                        pr = hc_r;
                        pg = hc_g;
                        pb = hc_b;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            vga.oHS      <= 1'b1;
            vga.oVS      <= 1'b1;
            vga.oBLANK_n <= 1'b0;
            vga.r_data   <= '0;
            vga.g_data   <= '0;
            vga.b_data   <= '0;
            frame_tick   <= 1'b0;
        end else begin
            vga.oHS      <= !((int'(h) >= HS_START) && (int'(h) < HS_END));
            vga.oVS      <= !((int'(v) >= VS_START) && (int'(v) < VS_END));
            vga.oBLANK_n <= active;
            vga.r_data   <= pr;
            vga.g_data   <= pg;
            vga.b_data   <= pb;
            frame_tick   <= frame_end;
        end
    end

    assign scene = scene_q;
endmodule
